data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Data-memory responder for the RV32IM datapath's load/store port: accepts one word-addressed request at a time over a valid/ready handshake and answers with a single-cycle response pulse after a fixed number of wait states. It is the memory-side counterpart of the datapath's load/store initiator. It provides byte-lane writes for SB/SH/SW and full-word reads, with the core doing load extraction and sign/zero extension. It also flags misaligned and out-of-range accesses.

## Interface
- DEPTH_WORDS, 1024: number of 32-bit words; power of two, 16..65536.
- WAIT_STATES, 1: extra cycles between accept and response; 0..15.
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept; a transfer occurs when req_valid && req_ready at a rising edge.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address; bits [1:0] must be 0.
- req_wdata  in  32  store data, lane-aligned (byte k in bits [8k+7:8k]).
- req_be  in  4  byte enables for stores; ignored for loads.
- rsp_valid  out  1  response pulse, exactly one cycle per accepted request.
- rsp_rdata  out  32  read word; valid only while rsp_valid is high.
- rsp_err  out  1  access fault; valid only while rsp_valid is high.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE
  - req_ready=1.
  - On a transfer, latch we/addr/wdata/be into request registers.
  - Go to WAIT with the counter loaded to WAIT_STATES-1, or go directly to RESP when WAIT_STATES==0.
- WAIT
  - req_ready=0.
  - Decrement the counter.
  - Go to RESP when the counter is 0.
- RESP
  - req_ready=0.
  - rsp_valid=1 for this one cycle only.
  - Return to IDLE unconditionally. There is no response backpressure; the initiator must sample in this cycle.
- Fault: rsp_err=1 if latched addr[1:0]!=0 or addr[31:2] >= DEPTH_WORDS.
  - A faulting store does not modify memory.
  - A faulting load returns rsp_rdata=0.
- Store:
  - Written lanes are those with be[k]=1; other lanes are preserved.
  - The write commits on the rising edge that ends the RESP cycle.
  - be=4'b0000 is a legal no-op with rsp_err=0.
  - A store's rsp_rdata is 0.
- Load: rsp_rdata is the word at addr[31:2] as it stands at the start of the RESP cycle.
- Word index width is log2(DEPTH_WORDS). Upper address bits are used only for the range check, never wrapped.
- Memory contents are not initialised or cleared by reset.

## Timing
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, state=IDLE, counter=0.
- req_ready rises on the first cycle after rst is released.
- Reset asserted mid-operation aborts the request. A pending store is dropped and no response is issued.
- Latency: a transfer accepted at edge N gives rsp_valid high during cycle N+1+WAIT_STATES.
- Throughput: one request per WAIT_STATES+2 cycles.
- req_ready is low from the accept edge until the cycle after RESP, so no request can be accepted in the RESP cycle.
- req_* inputs are don't-care outside the accept edge, because the request is latched.
- A load to the same word issued directly after a store observes the stored data.
- rsp_rdata and rsp_err are driven to 0 whenever rsp_valid=0.

## Structure
- Package dmem_pkg holds:
  - the state enum (IDLE, WAIT, RESP);
  - the WORD_W=32 and BE_W=4 constants;
  - the function word_index(addr, depth).
- Sub-module dmem_array holds the storage: a byte-lane-enabled synchronous-write, asynchronous-read array parameterised by DEPTH_WORDS.
- The top level holds the FSM, wait counter, request registers and fault check.

## Test plan
- **Reset:** hold rst=0 for 3 cycles with req_valid=1 → req_ready=0 and rsp_valid=0 throughout; no memory change.
- **Full-word store and load, WAIT_STATES=1:**
  - Store 0xDEADBEEF to 0x10 with be=4'hF, then load 0x10.
  - Each rsp_valid pulse lands 2 cycles after its accept edge.
  - The load returns 0xDEADBEEF with rsp_err=0.
- **Byte-lane store:**
  - Write 0x11223344 to 0x20, then store 0xAABBCCDD with be=4'b0101.
  - A load of 0x20 returns 0x11BB33DD.
- **Faults:**
  - A load of 0x22 gives rsp_err=1 and rsp_rdata=0.
  - A store to 4*DEPTH_WORDS gives rsp_err=1, and a following load of word 0 is unchanged.
- **WAIT_STATES=0 back-to-back:**
  - Hold req_valid=1 for 4 loads.
  - Accepts happen every 2 cycles.
  - Exactly 4 rsp_valid pulses, each one cycle wide.
- **Reset mid-operation:**
  - Accept a store of 0xCAFEF00D to 0x40, then assert rst during WAIT (WAIT_STATES=3).
  - No rsp_valid pulse; after release, a load of 0x40 returns the prior contents.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder: FSM states,
// word/byte-enable widths and byte-address to word-index conversion.
package dmem_pkg;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   localparam int WORD_W = 32;
   localparam int BE_W   = 4;

   // Word index inside a power-of-two array; out-of-range bits are dropped
   // here, so the range check must look at the full address separately.
   function automatic logic [31:0] word_index(input logic [31:0] addr,
                                              input int unsigned depth);
      return (addr >> 2) & (depth - 1);
   endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage with per-byte write enables: synchronous write,
// asynchronous read from the same index. Contents are never reset.
module dmem_array
   import dmem_pkg::*;
#(
   parameter  int DEPTH_WORDS = 1024,
   localparam int AW          = $clog2(DEPTH_WORDS)
)(
   input  logic              clk,
   input  logic              we,
   input  logic [BE_W-1:0]   be,
   input  logic [AW-1:0]     idx,
   input  logic [WORD_W-1:0] wdata,
   output logic [WORD_W-1:0] rdata
);

   logic [BE_W-1:0][7:0] mem [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int k = 0; k < BE_W; k++) begin
            if (be[k]) mem[idx][k] <= wdata[8*k +: 8];
         end
      end
   end

   assign rdata = mem[idx];

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the core's load/store port: one request at a
// time, fixed wait states, single-cycle response with fault flag.
module data_mem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_STATES = 1
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [31:0]       req_addr,
   input  logic [WORD_W-1:0] req_wdata,
   input  logic [BE_W-1:0]   req_be,
   output logic              rsp_valid,
   output logic [WORD_W-1:0] rsp_rdata,
   output logic              rsp_err
);

   localparam int         AW       = $clog2(DEPTH_WORDS);
   localparam logic [3:0] CNT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

   state_t              state, state_next;
   logic [3:0]          cnt, cnt_next;
   logic                we_q;
   logic [31:0]         addr_q;
   logic [WORD_W-1:0]   wdata_q;
   logic [BE_W-1:0]     be_q;
   logic                accept;
   logic                fault;
   logic                mem_we;
   logic [AW-1:0]       idx;
   logic [WORD_W-1:0]   mem_rdata;

   assign accept = req_valid && req_ready;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   // Request capture; req_* are don't-care once latched.
   always_ff @(posedge clk) begin
      if (accept) begin
         we_q    <= req_we;
         addr_q  <= req_addr;
         wdata_q <= req_wdata;
         be_q    <= req_be;
      end
   end

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      req_ready  = 1'b0;
      rsp_valid  = 1'b0;
      case (state)
         IDLE: begin
            req_ready = rst;
            if (req_valid) begin
               if (WAIT_STATES == 0) begin
                  state_next = RESP;
               end else begin
                  state_next = WAIT;
                  cnt_next   = CNT_LOAD;
               end
            end
         end
         WAIT: begin
            if (cnt == 4'd0) state_next = RESP;
            else             cnt_next   = cnt - 4'd1;
         end
         RESP: begin
            rsp_valid  = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Upper address bits are only range-checked, never wrapped into the array.
   assign fault  = (addr_q[1:0] != 2'b00) || ({2'b00, addr_q[31:2]} >= 32'(DEPTH_WORDS));
   assign idx    = AW'(word_index(addr_q, DEPTH_WORDS));
   assign mem_we = (state == RESP) && we_q && !fault && rst;

   assign rsp_rdata = (rsp_valid && !we_q && !fault) ? mem_rdata : '0;
   assign rsp_err   = rsp_valid && fault;

   dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
      .clk   (clk),
      .we    (mem_we),
      .be    (be_q),
      .idx   (idx),
      .wdata (wdata_q),
      .rdata (mem_rdata)
   );

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: three responders (1, 0 and 3 wait states) share one clock
// and reset; drivers queue expected responses, a negedge monitor checks them.
module tb_data_mem_responder;

   localparam int DEPTH = 1024;
   localparam int N     = 3;
   localparam int WS [N] = '{1, 0, 3};

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
      logic [31:0] cyc;
   } exp_t;

   logic        clk, rst;
   logic        req_valid [N];
   logic        req_ready [N];
   logic        req_we    [N];
   logic [31:0] req_addr  [N];
   logic [31:0] req_wdata [N];
   logic [3:0]  req_be    [N];
   logic        rsp_valid [N];
   logic [31:0] rsp_rdata [N];
   logic        rsp_err   [N];

   int          checks = 0;
   int          errors = 0;
   logic [31:0] cyc = '0;
   int          pulses [N] = '{default: 0};
   int          issued [N] = '{default: 0};
   exp_t        exp_q [N][$];

   for (genvar g = 0; g < N; g++) begin : g_dut
      data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS[g])) dut (
         .clk       (clk),
         .rst       (rst),
         .req_valid (req_valid[g]),
         .req_ready (req_ready[g]),
         .req_we    (req_we[g]),
         .req_addr  (req_addr[g]),
         .req_wdata (req_wdata[g]),
         .req_be    (req_be[g]),
         .rsp_valid (rsp_valid[g]),
         .rsp_rdata (rsp_rdata[g]),
         .rsp_err   (rsp_err[g])
      );
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 32'd1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      for (int i = 0; i < N; i++) begin
         if (!rst) begin
            check($sformatf("rst_ready%0d", i), {31'b0, req_ready[i]}, 32'd0);
            check($sformatf("rst_valid%0d", i), {31'b0, rsp_valid[i]}, 32'd0);
         end else if (rsp_valid[i]) begin
            pulses[i]++;
            if (exp_q[i].size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_rsp%0d actual=pulse required=none", i);
            end else begin
               e = exp_q[i].pop_front();
               check($sformatf("rdata%0d", i), rsp_rdata[i], e.rdata);
               check($sformatf("err%0d", i), {31'b0, rsp_err[i]}, {31'b0, e.err});
               check($sformatf("latency%0d", i), cyc, e.cyc);
            end
         end else begin
            check($sformatf("idle_out%0d", i), rsp_rdata[i] | {31'b0, rsp_err[i]}, 32'd0);
         end
      end
   end

   task automatic issue(input int i, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        input logic [31:0] exp_rdata, input logic exp_err,
                        input bit expect_rsp, input bit hold,
                        output logic [31:0] acc_cyc);
      int n = 0;
      req_valid[i] = 1'b1;
      req_we[i]    = we;
      req_addr[i]  = addr;
      req_wdata[i] = wdata;
      req_be[i]    = be;
      @(negedge clk);
      while (!req_ready[i] && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready[i]) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout%0d actual=no_ready required=ready", i);
         req_valid[i] = 1'b0;
         acc_cyc = '0;
         return;
      end
      @(posedge clk);
      #1;
      acc_cyc = cyc;
      if (expect_rsp) begin
         exp_q[i].push_back('{exp_rdata, exp_err, cyc + 32'(WS[i])});
         issued[i]++;
      end
      if (!hold) req_valid[i] = 1'b0;
   endtask

   task automatic st(input int i, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] be, input logic err);
      logic [31:0] c;
      issue(i, 1'b1, a, d, be, 32'h0, err, 1'b1, 1'b0, c);
   endtask

   task automatic ld(input int i, input logic [31:0] a, input logic [31:0] exp, input logic err);
      logic [31:0] c;
      issue(i, 1'b0, a, 32'h0, 4'h0, exp, err, 1'b1, 1'b0, c);
   endtask

   initial begin
      logic [31:0] acc [4];
      logic [31:0] c;
      rst = 1'b0;
      for (int i = 0; i < N; i++) begin
         req_valid[i] = 1'b1;
         req_we[i]    = 1'b1;
         req_addr[i]  = 32'h0;
         req_wdata[i] = 32'hFFFF_FFFF;
         req_be[i]    = 4'hF;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) req_valid[i] = 1'b0;
      rst = 1'b1;

      // one wait state: store/load, byte lanes, faults, empty byte enable
      st(0, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b0);
      ld(0, 32'h10, 32'hDEAD_BEEF, 1'b0);
      st(0, 32'h20, 32'h1122_3344, 4'hF, 1'b0);
      st(0, 32'h20, 32'hAABB_CCDD, 4'b0101, 1'b0);
      ld(0, 32'h20, 32'h11BB_33DD, 1'b0);
      ld(0, 32'h22, 32'h0, 1'b1);
      st(0, 32'h0, 32'h55AA_55AA, 4'hF, 1'b0);
      st(0, 32'(4 * DEPTH), 32'h9999_9999, 4'hF, 1'b1);
      ld(0, 32'h0, 32'h55AA_55AA, 1'b0);
      st(0, 32'h10, 32'h1234_5678, 4'h0, 1'b0);
      ld(0, 32'h10, 32'hDEAD_BEEF, 1'b0);

      // zero wait states: back-to-back loads with valid held high
      for (int k = 0; k < 4; k++) st(1, 32'(4 * k), 32'h1000_0000 + 32'(k), 4'hF, 1'b0);
      for (int k = 0; k < 4; k++)
         issue(1, 1'b0, 32'(4 * k), 32'h0, 4'h0, 32'h1000_0000 + 32'(k), 1'b0,
               1'b1, (k < 3), acc[k]);
      for (int k = 1; k < 4; k++) check($sformatf("accept_gap%0d", k), acc[k] - acc[k-1], 32'd2);

      // three wait states: reset lands in WAIT and drops the store
      st(2, 32'h40, 32'h0BAD_C0DE, 4'hF, 1'b0);
      issue(2, 1'b1, 32'h40, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0, 1'b0, 1'b0, c);
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      ld(2, 32'h40, 32'h0BAD_C0DE, 1'b0);

      repeat (10) @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         check($sformatf("pending%0d", i), 32'(exp_q[i].size()), 32'd0);
         check($sformatf("pulses%0d", i), 32'(pulses[i]), 32'(issued[i]));
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
